// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter and its future
// receiver: frame state encodings, the minimum clocks-per-bit value and the
// parity-mode encodings.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // Smallest usable clocks-per-bit; programmed values below this are raised to it.
    localparam int DIV_MIN = 2;

    // Parity mode as latched for one frame.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    function automatic parity_e parity_mode(input logic en, input logic odd);
        if (!en) begin
            return PAR_NONE;
        end
        return odd ? PAR_ODD : PAR_EVEN;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Bit-period timer shared by the UART TX and RX blocks. Latches the
// clocks-per-bit value (raised to DIV_MIN) on load and strobes bit_end on the
// last cycle of every bit while run is high.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   load          latch clks_per_bit and restart the count at 0
//   run           count while high; the counter holds at 0 when low
//   clks_per_bit  requested bit period in clock cycles
//   bit_end       high on the last cycle of the current bit
// ---------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] clks_per_bit,
    output logic             bit_end
);

    localparam logic [DIV_W-1:0] MIN_N = DIV_W'(DIV_MIN);

    logic [DIV_W-1:0] n_q;
    logic [DIV_W-1:0] cnt;

    // Clamping at latch time keeps n_q >= 2, so n_q - 1 never underflows and
    // the counter always meets its terminal value before wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= MIN_N;
            cnt <= '0;
        end else if (load) begin
            n_q <= (clks_per_bit < MIN_N) ? MIN_N : clks_per_bit;
            cnt <= '0;
        end else if (run && !bit_end) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign bit_end = run && (cnt == n_q - 1'b1);

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter: DATA_W data bits (LSB first),
// optional even/odd parity, one or two stop bits and a programmable bit
// period. A one-entry holding buffer lets frames run back-to-back.
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous, active-high reset
//   i_tx_dv         byte valid; transfer when i_tx_dv && o_tx_ready
//   o_tx_ready      holding buffer empty and not in reset
//   i_tx_byte       data to send
//   i_clks_per_bit  clocks per bit (0 and 1 behave as 2)
//   i_parity_en     append a parity bit
//   i_parity_odd    0 = even parity, 1 = odd parity
//   i_stop2         two stop bits
//   o_tx_active     high while a frame is on the line
//   o_tx_serial     registered serial line, idles high
//   o_tx_done       one-cycle pulse after the last stop cycle
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_dv,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_byte,
    input  logic [DIV_W-1:0]  i_clks_per_bit,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_stop2,
    output logic              o_tx_active,
    output logic              o_tx_serial,
    output logic              o_tx_done
);

    localparam int              IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shift;
    logic [IDX_W-1:0]  bit_idx;
    parity_e           par_mode;
    logic              par_bit;
    logic              stop2_q;
    logic              stop_second;

    logic              bit_end;
    logic              take;
    logic              last_stop;
    logic              load_idle;
    logic              load_b2b;
    logic              load;
    logic [DATA_W-1:0] load_data;

    assign o_tx_ready = !hold_valid && !i_rst;
    assign take       = i_tx_dv && o_tx_ready;
    assign last_stop  = !stop2_q || stop_second;

    // From IDLE an accepted byte goes straight to the line (start bit on the
    // next cycle) instead of parking in the buffer for a cycle.
    assign load_idle = (state == S_IDLE) && (hold_valid || take);
    assign load_b2b  = (state == S_STOP) && bit_end && last_stop && hold_valid;
    assign load      = load_idle || load_b2b;
    assign load_data = hold_valid ? hold_data : i_tx_byte;

    uart_bit_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk          (i_clk),
        .rst          (i_rst),
        .load         (load),
        .run          (state != S_IDLE),
        .clks_per_bit (i_clks_per_bit),
        .bit_end      (bit_end)
    );

    // NOTE: every register here uses <= so all branches see the pre-edge
    // values of state, shift and hold_valid; data registers are reset too so
    // no X ever reaches the line after a mid-frame reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            shift       <= '0;
            bit_idx     <= '0;
            par_mode    <= PAR_NONE;
            par_bit     <= 1'b0;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;

            if (take && !load) begin
                hold_valid <= 1'b1;
                hold_data  <= i_tx_byte;
            end

            if (load) begin
                // Frame configuration is frozen here for the whole frame.
                hold_valid  <= 1'b0;
                shift       <= load_data;
                par_mode    <= parity_mode(i_parity_en, i_parity_odd);
                par_bit     <= (^load_data) ^ i_parity_odd;
                stop2_q     <= i_stop2;
                stop_second <= 1'b0;
                bit_idx     <= '0;
                state       <= S_START;
                o_tx_serial <= 1'b0;
                o_tx_active <= 1'b1;
                if (load_b2b) begin
                    o_tx_done <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        o_tx_serial <= 1'b1;
                        o_tx_active <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state       <= S_DATA;
                            o_tx_serial <= shift[0];
                            shift       <= shift >> 1;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            if (bit_idx == LAST_IDX) begin
                                if (par_mode != PAR_NONE) begin
                                    state       <= S_PARITY;
                                    o_tx_serial <= par_bit;
                                end else begin
                                    state       <= S_STOP;
                                    o_tx_serial <= 1'b1;
                                end
                            end else begin
                                bit_idx     <= bit_idx + 1'b1;
                                o_tx_serial <= shift[0];
                                shift       <= shift >> 1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state       <= S_STOP;
                            o_tx_serial <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (!last_stop) begin
                                stop_second <= 1'b1;
                            end else begin
                                // Back-to-back case is taken by the load path above.
                                stop_second <= 1'b0;
                                o_tx_done   <= 1'b1;
                                state       <= S_IDLE;
                                o_tx_active <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        o_tx_serial <= 1'b1;
                        o_tx_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It is the next generation of the fixed 8N1 transmitter.
- Adds a configurable data width, optional even/odd parity, 1 or 2 stop bits and a runtime baud divisor.
- Adds a one-entry holding buffer with a valid/ready handshake, so frames run back-to-back with no idle gap.
- Sits between the packet/command logic and the board TX pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
DIV_W, 16, width of the runtime clocks-per-bit divisor and of the bit counter.

Ports:
i_clk  input  1  system clock; the only clock.
i_rst  input  1  synchronous, active-high reset.
i_tx_dv  input  1  byte valid; a transfer occurs on an edge where i_tx_dv and o_tx_ready are both 1.
o_tx_ready  output  1  holding buffer empty; equals !hold_valid && !i_rst.
i_tx_byte  input  DATA_W  data to send, LSB first.
i_clks_per_bit  input  DIV_W  clocks per bit (N); values 0 and 1 are treated as 2.
i_parity_en  input  1  1 = append a parity bit.
i_parity_odd  input  1  0 = even parity, 1 = odd parity.
i_stop2  input  1  1 = two stop bits.
o_tx_active  output  1  high while a frame is on the line.
o_tx_serial  output  1  registered serial line; idles high.
o_tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- One clock (i_clk); reset (i_rst) is synchronous and active-high. While reset is asserted and after it:
  - o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_tx_ready=0 during reset.
  - FSM=IDLE, holding buffer empty, counters 0.
- Holding buffer:
  - Handshake at edge E: byte is captured and hold_valid=1, so o_tx_ready=0 after E.
  - An FSM load clears hold_valid at the same edge.
  - i_tx_dv while not ready is ignored; no overwrite.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Every bit lasts exactly N cycles, counted by the bit counter from 0 to N-1.
- Load, performed at IDLE with hold_valid=1, or at the last STOP cycle with hold_valid=1:
  - Copy the byte to the shift register.
  - Latch N, parity_en, parity_odd and stop2. These stay fixed for the whole frame; input changes mid-frame are ignored.
  - Enter START and drive o_tx_serial=0. o_tx_active=1.
  - Latency: handshake at edge E from IDLE gives start bit from edge E+1.
- START, N cycles -> DATA.
- DATA: DATA_W bits, LSB first.
  - After the last bit: go to PARITY if parity_en, else STOP.
- PARITY, N cycles: bit = XOR(data), inverted when parity_odd.
- STOP: line=1 for N cycles, or 2N when stop2. On the edge ending the last stop cycle:
  - o_tx_done=1 for exactly one cycle.
  - If hold_valid: load and go to START (back-to-back, o_tx_active stays 1, no idle cycle).
  - Else: go to IDLE with o_tx_active=0.
- Frame length = N * (1 + DATA_W + parity_en + 1 + stop2) cycles.
- Bit counter is DIV_W wide. The clamp (N<2 treated as 2) is applied at latch time, so the counter never wraps.
- Reset mid-frame: at the next edge the line returns to 1, the FSM goes to IDLE and the buffered byte is discarded. No o_tx_done is issued.
- Handshake in the same cycle as a back-to-back load is not possible: ready=0 while hold_valid=1.
- A handshake on the cycle right after the load is accepted.
- Unreachable state encodings go to IDLE with the line high.

Decomposition:
- Package uart_pkg holds:
  - state enum / localparams for IDLE, START, DATA, PARITY, STOP;
  - the DIV minimum constant (2);
  - parity-mode encodings, shared with the future RX successor.
- One natural sub-module, uart_bit_timer. It holds the latched-N bit counter and outputs a bit_end strobe for the last cycle of each bit. It is reusable by the RX block.

Test Plan:
1. N=4, DATA_W=8, byte 0xA5, no parity, 1 stop, dv at edge E -> line 0 from E+1, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1; o_tx_done pulses once at E+41; 40-cycle frame; active high throughout.
2. Same byte with parity_en=1 -> even: parity bit 0, 44-cycle frame; odd: parity bit 1. With stop2=1 added -> 48-cycle frame.
3. Back-to-back: send 0x55, then assert dv with 0x0F while ready returns high -> two frames, 80 contiguous cycles, no idle high gap beyond the stop bit, active never drops, two done pulses 40 cycles apart.
4. N programmed to 1 and to 0 -> every bit lasts 2 cycles; 8N1 frame = 20 cycles.
5. Change i_clks_per_bit from 4 to 8 and toggle parity_en mid-frame -> current frame is unchanged (40 cycles); the next frame uses N=8 (80 cycles, or 88 with parity).
6. Assert i_rst for 1 cycle mid-DATA with a byte buffered -> line high at the next edge, no done pulse, ready low during reset and high after; the buffered byte is never sent.
